pdec_us_buf: RTL and testbench

PDEC_US_BUF -- requirements
Module: pdec_us_buf

---
 rtl/pdec_us_buf_if.sv | 24 ++
 rtl/pdec_us_buf.sv | 107 ++++++++++
 tb/tb_pdec_us_buf.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pdec_us_buf_if.sv
// Handshake bundle for the partial-sum group buffer: decided-bit input channel
// and completed-group output channel towards the butterfly stage.
interface pdec_us_buf_if #(
  parameter int unsigned I_W = 4
) ();
  logic           u_vld;
  logic           u_bit;
  logic           u_sof;
  logic           u_rdy;
  logic           out_vld;
  logic           out_rdy;
  logic [I_W-1:0] out_in0;
  logic [I_W-1:0] out_in1;

  modport slave (
    input  u_vld, u_bit, u_sof, out_rdy,
    output u_rdy, out_vld, out_in0, out_in1
  );

  modport master (
    output u_vld, u_bit, u_sof, out_rdy,
    input  u_rdy, out_vld, out_in0, out_in1
  );
endinterface

// File: rtl/pdec_us_buf.sv
// Collects 2*I_W decided bits into a group and presents it to the butterfly
// stage; a u_sof mid-group discards the partial group and counts the drop.
module pdec_us_buf #(
  parameter int unsigned I_W   = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  pdec_us_buf_if.slave     bus,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             busy
);
  localparam int unsigned GrpW = 2 * I_W;
  localparam int unsigned IdxW = $clog2(GrpW) + 1;

  typedef enum logic [1:0] {StIdle, StFillA, StFillB, StHold} state_e;

  // With I_W=1 the first half is complete after index 0, so go straight to FillB.
  function automatic state_e first_state();
    if (I_W == 1) return StFillB;
    return StFillA;
  endfunction

  state_e           state_q;
  logic [IdxW-1:0]  idx_q;
  logic [GrpW-1:0]  data_q;
  logic [CNT_W-1:0] drop_q;
  logic             vld_q;
  logic             busy_q;

  logic            filling;
  logic            accept;
  logic            restart;
  logic [IdxW-1:0] wr_idx;

  assign filling    = (state_q == StFillA) || (state_q == StFillB);
  assign bus.u_rdy  = (state_q != StHold) || bus.out_rdy;
  assign accept     = bus.u_vld && bus.u_rdy;
  assign restart    = filling && bus.u_sof;
  assign wr_idx     = (filling && !bus.u_sof) ? idx_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      data_q  <= '0;
      drop_q  <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      if (accept) begin
        for (int unsigned i = 0; i < GrpW; i++) begin
          if (wr_idx == IdxW'(i)) data_q[i] <= bus.u_bit;
        end
        idx_q <= wr_idx + IdxW'(1);
      end

      if (accept && restart && (drop_q != '1)) begin
        drop_q <= drop_q + CNT_W'(1);
      end

      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q <= first_state();
            busy_q  <= 1'b1;
          end
        end
        StFillA: begin
          if (accept && !bus.u_sof && (idx_q == IdxW'(I_W - 1))) begin
            state_q <= StFillB;
          end
        end
        StFillB: begin
          if (accept) begin
            if (bus.u_sof) begin
              state_q <= first_state();
            end else if (idx_q == IdxW'(GrpW - 1)) begin
              state_q <= StHold;
              vld_q   <= 1'b1;
            end
          end
        end
        StHold: begin
          if (bus.out_rdy) begin
            vld_q <= 1'b0;
            if (accept) begin
              // Handoff: the bit accepted this cycle opens the next group.
              state_q <= first_state();
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              idx_q   <= '0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.out_vld = vld_q;
  assign bus.out_in0 = data_q[I_W-1:0];
  assign bus.out_in1 = data_q[GrpW-1:I_W];
  assign drop_cnt    = drop_q;
  assign busy        = busy_q;
endmodule

// File: tb/tb_pdec_us_buf.sv
// Bench for pdec_us_buf: vector table, directed corner sequences and a random
// stream checked against a queue-based group model, on I_W=4 and I_W=1 instances.
module tb_pdec_us_buf;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pdec_us_buf_if #(.I_W(4)) bus4 ();
  pdec_us_buf_if #(.I_W(1)) bus1 ();
  logic [1:0]  drop4;
  logic [15:0] drop1;
  logic        busy4;
  logic        busy1;

  pdec_us_buf #(.I_W(4), .CNT_W(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4), .drop_cnt(drop4), .busy(busy4)
  );
  pdec_us_buf #(.I_W(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .drop_cnt(drop1), .busy(busy1)
  );

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic rdy, vld, busy;
    longint unsigned in0, in1, drop;
  } obs_t;

  typedef struct {
    logic v, b, s, r;
    logic e_rdy, e_vld, e_busy, chk_d;
    logic [3:0] e0, e1;
  } vec_t;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic drv(input int w, input logic v, input logic b, input logic s, input logic r);
    if (w == 4) begin
      bus4.u_vld = v; bus4.u_bit = b; bus4.u_sof = s; bus4.out_rdy = r;
    end else begin
      bus1.u_vld = v; bus1.u_bit = b; bus1.u_sof = s; bus1.out_rdy = r;
    end
  endtask

  function automatic obs_t obs(input int w);
    obs_t o;
    if (w == 4) begin
      o.rdy = bus4.u_rdy; o.vld = bus4.out_vld; o.busy = busy4;
      o.in0 = 64'(bus4.out_in0); o.in1 = 64'(bus4.out_in1); o.drop = 64'(drop4);
    end else begin
      o.rdy = bus1.u_rdy; o.vld = bus1.out_vld; o.busy = busy1;
      o.in0 = 64'(bus1.out_in0); o.in1 = 64'(bus1.out_in1); o.drop = 64'(drop1);
    end
    return o;
  endfunction

  // Drive one cycle's inputs at the falling edge; outputs sampled after #1 are pre-edge.
  task automatic cyc(input int w, input logic v, input logic b, input logic s, input logic r);
    @(negedge clk);
    drv(w, v, b, s, r);
    #1;
  endtask

  task automatic do_reset();
    drv(4, 0, 0, 0, 1);
    drv(1, 0, 0, 0, 1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rand_run(input int w, input int groups);
    int iw = (w == 4) ? 4 : 1;
    longint unsigned dmax = (w == 4) ? 3 : 65535;
    longint unsigned drop = 0;
    longint unsigned e0, e1;
    bit cur[$];
    bit held[$];
    bit holding = 0;
    bit acc;
    int done = 0;
    int cycles = 0;
    logic v, b, s, r;
    obs_t o;
    do_reset();
    while (done < groups && cycles < 60 * groups + 1000) begin
      v = ($urandom_range(0, 9) < 7);
      b = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 19) == 0);
      r = ($urandom_range(0, 3) != 0);
      cyc(w, v, b, s, r);
      cycles++;
      o = obs(w);
      chk("rnd_u_rdy", o.rdy, !holding || r);
      chk("rnd_out_vld", o.vld, holding);
      chk("rnd_drop_cnt", o.drop, drop);
      acc = v && (!holding || r);
      if (holding && r) begin
        e0 = 0; e1 = 0;
        for (int k = 0; k < iw; k++) begin
          e0 |= longint'(held[k]) << k;
          e1 |= longint'(held[k + iw]) << k;
        end
        chk("rnd_out_in0", o.in0, e0);
        chk("rnd_out_in1", o.in1, e1);
        holding = 0;
        done++;
      end
      if (acc) begin
        if (s && cur.size() > 0) begin
          if (drop < dmax) drop++;
          cur.delete();
        end
        cur.push_back(b);
        if (cur.size() == 2 * iw) begin
          held = cur;
          cur.delete();
          holding = 1;
        end
      end
    end
    chk("rnd_groups_done", done, groups);
  endtask

  initial begin
    vec_t tbl[10];
    logic [7:0] bits;
    logic [7:0] p;
    obs_t o;

    // Reset state
    do_reset();
    #1;
    o = obs(4);
    chk("rst_u_rdy", o.rdy, 1);
    chk("rst_out_vld", o.vld, 0);
    chk("rst_busy", o.busy, 0);
    chk("rst_drop", o.drop, 0);
    chk("rst_in0", o.in0, 0);
    chk("rst_in1", o.in1, 0);

    // Back-to-back group, out_rdy=1; first bit carries u_sof in IDLE (no drop)
    bits = 8'b0100_1101;
    for (int i = 0; i < 10; i++) begin
      tbl[i] = '{v: (i < 8), b: (i < 8) ? bits[i] : 1'b0, s: (i == 0), r: 1'b1,
                 e_rdy: 1'b1, e_vld: (i == 8), e_busy: (i != 0 && i != 9),
                 chk_d: (i == 8), e0: 4'b1101, e1: 4'b0100};
    end
    for (int i = 0; i < 10; i++) begin
      cyc(4, tbl[i].v, tbl[i].b, tbl[i].s, tbl[i].r);
      o = obs(4);
      chk("tbl_u_rdy", o.rdy, tbl[i].e_rdy);
      chk("tbl_out_vld", o.vld, tbl[i].e_vld);
      chk("tbl_busy", o.busy, tbl[i].e_busy);
      if (tbl[i].chk_d) begin
        chk("tbl_out_in0", o.in0, tbl[i].e0);
        chk("tbl_out_in1", o.in1, tbl[i].e1);
      end
    end
    chk("tbl_drop", obs(4).drop, 0);

    // Backpressure stall then same-cycle handoff
    do_reset();
    p = 8'hA5;
    for (int i = 0; i < 8; i++) cyc(4, 1, p[i], 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(4, 1, 0, 0, 0);
      o = obs(4);
      chk("stall_u_rdy", o.rdy, 0);
      chk("stall_out_vld", o.vld, 1);
      chk("stall_in0", o.in0, 4'h5);
      chk("stall_in1", o.in1, 4'hA);
    end
    p = 8'hC3;
    cyc(4, 1, p[0], 1, 1);
    chk("handoff_u_rdy", obs(4).rdy, 1);
    for (int i = 1; i < 8; i++) begin
      cyc(4, 1, p[i], 0, 1);
      if (i == 1) chk("handoff_vld_drop", obs(4).vld, 0);
    end
    cyc(4, 0, 0, 0, 1);
    o = obs(4);
    chk("handoff_vld", o.vld, 1);
    chk("handoff_in0", o.in0, 4'h3);
    chk("handoff_in1", o.in1, 4'hC);
    chk("handoff_drop", o.drop, 0);

    // Mid-group u_sof discards the partial group
    do_reset();
    for (int i = 0; i < 3; i++) cyc(4, 1, 1, 0, 1);
    p = 8'h96;
    cyc(4, 1, p[0], 1, 1);
    for (int i = 1; i < 8; i++) cyc(4, 1, p[i], 0, 1);
    cyc(4, 0, 0, 0, 1);
    o = obs(4);
    chk("sof_vld", o.vld, 1);
    chk("sof_in0", o.in0, 4'h6);
    chk("sof_in1", o.in1, 4'h9);
    chk("sof_drop", o.drop, 1);

    // drop_cnt saturation with CNT_W=2
    do_reset();
    cyc(4, 1, 1, 0, 1);
    for (int k = 1; k <= 4; k++) begin
      cyc(4, 1, 0, 0, 1);
      cyc(4, 1, 1, 1, 1);
      cyc(4, 0, 0, 0, 1);
      chk("sat_drop", obs(4).drop, (k < 3) ? k : 3);
    end

    // I_W=1 group, then async reset during FILL_B of the next group
    do_reset();
    cyc(1, 1, 1, 0, 1);
    cyc(1, 1, 1, 0, 1);
    cyc(1, 0, 0, 0, 1);
    o = obs(1);
    chk("iw1_vld", o.vld, 1);
    chk("iw1_in0", o.in0, 1);
    chk("iw1_in1", o.in1, 1);
    cyc(1, 1, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    chk("iw1_fill_busy", obs(1).busy, 1);
    #2 rst_n = 1'b0;
    #1;
    o = obs(1);
    chk("iw1_rst_vld", o.vld, 0);
    chk("iw1_rst_busy", o.busy, 0);
    chk("iw1_rst_drop", o.drop, 0);
    chk("iw1_rst_u_rdy", o.rdy, 1);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 1, 0, 0, 1);
    cyc(1, 1, 1, 0, 1);
    cyc(1, 0, 0, 0, 1);
    o = obs(1);
    chk("iw1_post_vld", o.vld, 1);
    chk("iw1_post_in0", o.in0, 0);
    chk("iw1_post_in1", o.in1, 1);

    // Random streams against the group model
    rand_run(4, 1000);
    rand_run(1, 1000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
